// File: rtl/fp_rffp_stream.sv
// Streaming multi-lane float to reduced-format float converter, two register stages.
// Define FP_RFFP_ROUND_EN for round-to-nearest-even; otherwise dropped mantissa bits are truncated.
`timescale 1ns/1ps

module fp_rffp_stream #(
    parameter int FP_WIDTH       = 16,
    parameter int EXP_WIDTH      = 8,
    parameter int MANTISSA_WIDTH = 7,
    parameter int RFFP_EXP_WIDTH = 6,
    parameter int RFFP_MAN_WIDTH = 5,
    parameter int LANES          = 4
) (
    input  logic                                                     clk,
    input  logic                                                     rst,
    input  logic                                                     in_valid,
    output logic                                                     in_ready,
    input  logic [LANES*FP_WIDTH-1:0]                                in_data,
    output logic                                                     out_valid,
    input  logic                                                     out_ready,
    output logic [LANES*(1+RFFP_EXP_WIDTH+RFFP_MAN_WIDTH)-1:0]       out_data,
    input  logic                                                     stat_clear,
    output logic [15:0]                                              sat_count,
    output logic [15:0]                                              flush_count
);

    localparam int RW       = 1 + RFFP_EXP_WIDTH + RFFP_MAN_WIDTH;
    localparam int EW       = EXP_WIDTH + 2;
    localparam int DROP     = MANTISSA_WIDTH - RFFP_MAN_WIDTH;
    localparam int IN_BIAS  = 2**(EXP_WIDTH-1) - 1;
    localparam int OUT_BIAS = 2**(RFFP_EXP_WIDTH-1) - 1;
    localparam int MAX_EXP  = 2**RFFP_EXP_WIDTH - 1;

    localparam logic signed [EW-1:0] BIAS_ADJ = EW'(OUT_BIAS - IN_BIAS);
    localparam logic signed [EW-1:0] MAX_E    = EW'(MAX_EXP);
    localparam logic signed [EW-1:0] E_ZERO   = '0;

    // Stage 1 state: sign, rebiased+rounded exponent, kept mantissa, zero-exponent flag
    logic                             s1_valid_reg;
    logic [LANES-1:0]                 s1_sign_reg;
    logic [LANES-1:0]                 s1_zero_reg;
    logic [LANES*EW-1:0]              s1_exp_reg;
    logic [LANES*RFFP_MAN_WIDTH-1:0]  s1_man_reg;

    logic [LANES-1:0]                 s1_sign_next;
    logic [LANES-1:0]                 s1_zero_next;
    logic [LANES*EW-1:0]              s1_exp_next;
    logic [LANES*RFFP_MAN_WIDTH-1:0]  s1_man_next;

    // Stage 2 state: packed result plus per-lane flags feeding the statistics
    logic                             out_valid_reg;
    logic [LANES*RW-1:0]              out_data_reg;
    logic [LANES-1:0]                 s2_sat_reg;
    logic [LANES-1:0]                 s2_flush_reg;

    logic [LANES*RW-1:0]              pack_next;
    logic [LANES-1:0]                 sat_flag;
    logic [LANES-1:0]                 flush_flag;

    logic [15:0]                      sat_count_reg;
    logic [15:0]                      flush_count_reg;
    logic [15:0]                      sat_count_next;
    logic [15:0]                      flush_count_next;
    logic [16:0]                      sat_sum;
    logic [16:0]                      flush_sum;

    logic s2_advance;
    logic s1_advance;
    logic in_fire;
    logic out_fire;

    assign s2_advance = !out_valid_reg || out_ready;
    assign s1_advance = !s1_valid_reg || s2_advance;
    assign in_ready   = s1_advance;
    assign in_fire    = in_valid && s1_advance;
    assign out_fire   = out_valid_reg && out_ready;

    assign out_valid   = out_valid_reg;
    assign out_data    = out_data_reg;
    assign sat_count   = sat_count_reg;
    assign flush_count = flush_count_reg;

    genvar gi;
    generate
        for (gi = 0; gi < LANES; gi++) begin : g_lane
            logic [FP_WIDTH-1:0]        word;
            logic [EXP_WIDTH-1:0]       exp_in;
            logic [MANTISSA_WIDTH-1:0]  man_in;
            logic [RFFP_MAN_WIDTH-1:0]  kept;
            logic signed [EW-1:0]       exp_rebias;
            logic                       round_up;
            logic [RFFP_MAN_WIDTH:0]    man_sum;
            logic                       carry;
            logic signed [EW-1:0]       e;

            assign word       = in_data[gi*FP_WIDTH +: FP_WIDTH];
            assign exp_in     = word[FP_WIDTH-2 -: EXP_WIDTH];
            assign man_in     = word[MANTISSA_WIDTH-1:0];
            assign kept       = man_in[MANTISSA_WIDTH-1 -: RFFP_MAN_WIDTH];
            assign exp_rebias = $signed({2'b00, exp_in}) + BIAS_ADJ;

`ifdef FP_RFFP_ROUND_EN
            if (DROP > 0) begin : g_rne
                localparam logic [MANTISSA_WIDTH-1:0] STICKY_MASK =
                    (MANTISSA_WIDTH'(1) << (DROP-1)) - MANTISSA_WIDTH'(1);
                // guard set and (sticky or odd kept LSB) rounds up; exact half to even
                assign round_up = man_in[DROP-1] & ((|(man_in & STICKY_MASK)) | kept[0]);
            end else begin : g_exact
                assign round_up = 1'b0;
            end
`else
            assign round_up = 1'b0;
`endif

            assign man_sum = {1'b0, kept} + {{RFFP_MAN_WIDTH{1'b0}}, round_up};
            assign carry   = man_sum[RFFP_MAN_WIDTH];

            assign s1_sign_next[gi]                                  = word[FP_WIDTH-1];
            assign s1_zero_next[gi]                                  = (exp_in == '0);
            assign s1_man_next[gi*RFFP_MAN_WIDTH +: RFFP_MAN_WIDTH]  = man_sum[RFFP_MAN_WIDTH-1:0];
            assign s1_exp_next[gi*EW +: EW] = exp_rebias + $signed({{(EW-1){1'b0}}, carry});

            // Range check on the registered exponent; flush wins over saturate
            assign e              = $signed(s1_exp_reg[gi*EW +: EW]);
            assign flush_flag[gi] = s1_zero_reg[gi] || (e <= E_ZERO);
            assign sat_flag[gi]   = !flush_flag[gi] && (e > MAX_E);

            assign pack_next[gi*RW +: RW] =
                flush_flag[gi] ? {s1_sign_reg[gi], {RFFP_EXP_WIDTH{1'b0}}, {RFFP_MAN_WIDTH{1'b0}}} :
                sat_flag[gi]   ? {s1_sign_reg[gi], {RFFP_EXP_WIDTH{1'b1}}, {RFFP_MAN_WIDTH{1'b1}}} :
                                 {s1_sign_reg[gi], e[RFFP_EXP_WIDTH-1:0],
                                  s1_man_reg[gi*RFFP_MAN_WIDTH +: RFFP_MAN_WIDTH]};
        end
    endgenerate

    function automatic logic [16:0] count_ones(input logic [LANES-1:0] v);
        logic [16:0] n;
        n = '0;
        for (int i = 0; i < LANES; i++) begin
            n = n + 17'(v[i]);
        end
        return n;
    endfunction

    always_comb begin
        sat_count_next   = sat_count_reg;
        flush_count_next = flush_count_reg;
        sat_sum          = {1'b0, sat_count_reg} + count_ones(s2_sat_reg);
        flush_sum        = {1'b0, flush_count_reg} + count_ones(s2_flush_reg);
        if (stat_clear) begin
            sat_count_next   = '0;
            flush_count_next = '0;
        end else if (out_fire) begin
            sat_count_next   = sat_sum[16]   ? 16'hFFFF : sat_sum[15:0];
            flush_count_next = flush_sum[16] ? 16'hFFFF : flush_sum[15:0];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid_reg    <= 1'b0;
            s1_sign_reg     <= '0;
            s1_zero_reg     <= '0;
            s1_exp_reg      <= '0;
            s1_man_reg      <= '0;
            out_valid_reg   <= 1'b0;
            out_data_reg    <= '0;
            s2_sat_reg      <= '0;
            s2_flush_reg    <= '0;
            sat_count_reg   <= '0;
            flush_count_reg <= '0;
        end else begin
            if (s1_advance) begin
                s1_valid_reg <= in_valid;
            end
            if (in_fire) begin
                s1_sign_reg <= s1_sign_next;
                s1_zero_reg <= s1_zero_next;
                s1_exp_reg  <= s1_exp_next;
                s1_man_reg  <= s1_man_next;
            end
            if (s2_advance) begin
                out_valid_reg <= s1_valid_reg;
            end
            // Data only moves forward with a real beat, so a stalled output stays put
            if (s2_advance && s1_valid_reg) begin
                out_data_reg <= pack_next;
                s2_sat_reg   <= sat_flag;
                s2_flush_reg <= flush_flag;
            end
            sat_count_reg   <= sat_count_next;
            flush_count_reg <= flush_count_next;
        end
    end

endmodule

// File: tb/tb_fp_rffp_stream.sv
// Scoreboard bench for fp_rffp_stream: random and directed beats checked against an integer model.
`timescale 1ns/1ps

module tb_fp_rffp_stream;

    localparam int LN       = 4;
    localparam int REW      = 6;
    localparam int RMW      = 5;
    localparam int IN_BIAS  = 127;
    localparam int OUT_BIAS = 31;
    localparam int DROP     = 2;

`ifdef FP_RFFP_ROUND_EN
    localparam logic [11:0] E86 = 12'h3E2;
    localparam logic [11:0] EFF = 12'h400;
`else
    localparam logic [11:0] E86 = 12'h3E1;
    localparam logic [11:0] EFF = 12'h3FF;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [63:0] in_data = '0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [47:0] out_data;
    logic        stat_clear = 1'b0;
    logic [15:0] sat_count;
    logic [15:0] flush_count;

    typedef struct {
        logic [47:0] data;
        int          ns;
        int          nf;
    } exp_t;

    exp_t sb[$];
    int   n_vec = 0;
    int   n_err = 0;
    int   n_beat = 0;
    int   mdl_sat = 0;
    int   mdl_flush = 0;
    int   rdy_mode = 0;
    int   stall_cnt = 0;

    fp_rffp_stream #(
        .FP_WIDTH(16), .EXP_WIDTH(8), .MANTISSA_WIDTH(7),
        .RFFP_EXP_WIDTH(6), .RFFP_MAN_WIDTH(5), .LANES(4)
    ) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .stat_clear(stat_clear), .sat_count(sat_count), .flush_count(flush_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        n_vec++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, req, $time);
        end
    endtask

    // Reference: plain integer rebias, optional round-half-even, then range classification
    task automatic model_lane(input logic [15:0] w, output logic [11:0] o, output int s, output int f);
        int ex, mn, e, kept;
`ifdef FP_RFFP_ROUND_EN
        int rem, half;
`endif
        ex   = int'(w[14:7]);
        mn   = int'(w[6:0]);
        e    = ex - IN_BIAS + OUT_BIAS;
        kept = mn >> DROP;
`ifdef FP_RFFP_ROUND_EN
        rem  = mn & ((1 << DROP) - 1);
        half = 1 << (DROP - 1);
        if (rem > half || (rem == half && (kept % 2) == 1)) kept++;
        if (kept == (1 << RMW)) begin
            kept = 0;
            e++;
        end
`endif
        s = 0;
        f = 0;
        if (ex == 0 || e <= 0) begin
            o = {w[15], 11'h000};
            f = 1;
        end else if (e > (1 << REW) - 1) begin
            o = {w[15], 11'h7FF};
            s = 1;
        end else begin
            o = {w[15], REW'(e), RMW'(kept)};
        end
    endtask

    task automatic model_beat(input logic [63:0] b, output logic [47:0] d, output int ns, output int nf);
        logic [11:0] o;
        int s, f;
        d  = '0;
        ns = 0;
        nf = 0;
        for (int k = 0; k < LN; k++) begin
            model_lane(b[k*16 +: 16], o, s, f);
            d[k*12 +: 12] = o;
            ns += s;
            nf += f;
        end
    endtask

    function automatic logic [15:0] rand_lane();
        logic [7:0] ex;
        ex = ($urandom_range(0, 3) != 0) ? 8'($urandom_range(90, 165)) : 8'($urandom);
        if ($urandom_range(0, 7) == 0) ex = 8'h00;
        return {1'($urandom), ex, 7'($urandom)};
    endfunction

    // Called at posedge+1; returns at posedge+1 after the accepting edge
    task automatic send(input logic [63:0] beat, input logic [47:0] d, input int ns, input int nf);
        logic acc;
        exp_t e;
        in_valid = 1'b1;
        in_data  = beat;
        acc      = 1'b0;
        for (int k = 0; k < 200 && !acc; k++) begin
            @(negedge clk);
            acc = in_ready;
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        if (!acc) begin
            n_vec++;
            n_err++;
            $display("FAIL send_timeout: got in_ready=0, expected 1 within 200 cycles");
        end else begin
            e.data = d;
            e.ns   = ns;
            e.nf   = nf;
            sb.push_back(e);
        end
    endtask

    task automatic send_rand();
        logic [63:0] b;
        logic [47:0] d;
        int ns, nf;
        for (int k = 0; k < LN; k++) b[k*16 +: 16] = rand_lane();
        model_beat(b, d, ns, nf);
        send(b, d, ns, nf);
    endtask

    task automatic drain();
        for (int k = 0; k < 300 && sb.size() != 0; k++) begin
            @(posedge clk);
            #1;
        end
        if (sb.size() != 0) begin
            n_vec++;
            n_err++;
            $display("FAIL drain: got %0d beats outstanding, expected 0", sb.size());
            sb.delete();
        end
    endtask

    initial begin
        forever begin
            @(posedge clk);
            #2;
            case (rdy_mode)
                0:       out_ready = 1'b1;
                1:       out_ready = ($urandom_range(0, 3) != 0);
                default: out_ready = !(stall_cnt >= 3 && stall_cnt <= 5);
            endcase
            stall_cnt++;
        end
    end

    // Monitor: counters, stall stability and beat ordering, sampled on the falling edge
    initial begin
        logic        stalled;
        logic [47:0] held;
        exp_t        e;
        stalled = 1'b0;
        held    = '0;
        forever begin
            @(negedge clk);
            if (rst) begin
                mdl_sat   = 0;
                mdl_flush = 0;
                stalled   = 1'b0;
            end else begin
                chk("sat_count", 64'(sat_count), 64'(mdl_sat));
                chk("flush_count", 64'(flush_count), 64'(mdl_flush));
                if (stalled) begin
                    chk("stall_valid", 64'(out_valid), 64'd1);
                    chk("stall_data", 64'(out_data), 64'(held));
                end
                stalled = out_valid && !out_ready;
                held    = out_data;
                if (out_valid && out_ready) begin
                    if (sb.size() == 0) begin
                        n_vec++;
                        n_err++;
                        $display("FAIL unexpected_beat: got 0x%0h, expected no beat", out_data);
                    end else begin
                        e = sb.pop_front();
                        chk("out_data", 64'(out_data), 64'(e.data));
                        $display("beat %0d out_data=0x%012h sat=%0d flush=%0d", n_beat, out_data, e.ns, e.nf);
                        n_beat++;
                        if (!stat_clear) begin
                            mdl_sat   = (mdl_sat + e.ns > 65535) ? 65535 : mdl_sat + e.ns;
                            mdl_flush = (mdl_flush + e.nf > 65535) ? 65535 : mdl_flush + e.nf;
                        end
                    end
                end
                if (stat_clear) begin
                    mdl_sat   = 0;
                    mdl_flush = 0;
                end
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got no finish, expected end before 2ms");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset state
        repeat (3) @(posedge clk);
        #1;
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_out_data", 64'(out_data), 64'd0);
        chk("rst_sat", 64'(sat_count), 64'd0);
        chk("rst_flush", 64'(flush_count), 64'd0);
        rst = 1'b0;
        @(negedge clk);
        chk("ready_after_rst", 64'(in_ready), 64'd1);
        @(posedge clk);
        #1;

        // Basic value and two-cycle latency
        send(64'h3F80_3F80_3F80_3F80, {4{12'h3E0}}, 0, 0);
        @(negedge clk);
        chk("latency_s1", 64'(out_valid), 64'd0);
        @(negedge clk);
        chk("latency_s2", 64'(out_valid), 64'd1);
        chk("latency_data", 64'(out_data), 64'({4{12'h3E0}}));
        @(posedge clk);
        #1;
        drain();

        // Rounding / truncation corner cases
        send({16'h3F86, 16'h3F80, 16'h3FFF, 16'h3F86}, {E86, 12'h3E0, EFF, E86}, 0, 0);
        drain();

        // Saturate and flush lanes with counters cleared first
        stat_clear = 1'b1;
        @(posedge clk);
        #1;
        stat_clear = 1'b0;
        send({16'h3F80, 16'h0000, 16'hB000, 16'h6400}, {12'h3E0, 12'h000, 12'h800, 12'h7FF}, 1, 2);
        drain();
        chk("sat_count_mix", 64'(sat_count), 64'd1);
        chk("flush_count_mix", 64'(flush_count), 64'd2);

        // Eight back-to-back beats with a three-cycle output stall
        rdy_mode  = 2;
        stall_cnt = 0;
        for (int i = 0; i < 8; i++) send_rand();
        drain();
        rdy_mode = 0;
        @(posedge clk);
        #1;

        // Clear in the same cycle as a saturating beat leaves the pipe
        send({4{16'h6400}}, {4{12'h7FF}}, 4, 0);
        @(posedge clk);
        #1;
        chk("clr_pre_valid", 64'(out_valid), 64'd1);
        stat_clear = 1'b1;
        @(posedge clk);
        #1;
        stat_clear = 1'b0;
        chk("clear_priority", 64'(sat_count), 64'd0);
        drain();

        // Random traffic with random backpressure and idle gaps
        rdy_mode = 1;
        for (int i = 0; i < 60; i++) begin
            send_rand();
            if ($urandom_range(0, 3) == 0) begin
                repeat ($urandom_range(1, 3)) @(posedge clk);
                #1;
            end
        end
        drain();
        rdy_mode = 0;
        @(posedge clk);
        #1;

        // Reset with two beats in flight
        send({4{16'h6400}}, {4{12'h7FF}}, 4, 0);
        send({4{16'h0000}}, {4{12'h000}}, 0, 4);
        rst = 1'b1;
        sb.delete();
        #1;
        chk("midrst_valid", 64'(out_valid), 64'd0);
        chk("midrst_data", 64'(out_data), 64'd0);
        chk("midrst_sat", 64'(sat_count), 64'd0);
        chk("midrst_flush", 64'(flush_count), 64'd0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        chk("post_rst_ready", 64'(in_ready), 64'd1);

        // Recovery after reset
        for (int i = 0; i < 4; i++) send_rand();
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
